// File: rtl/demux_1x4.sv
// Registered 1-to-4 demultiplexer.
// D is routed to lane s of Y through a two-level tree of 1-to-2 demux cells. Unselected lanes
// are zero. The result is registered, so Y follows the sampled D/s one clock later.
// Lane k occupies Y[k*WIDTH +: WIDTH].
module demux_1x4 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [WIDTH-1:0]     D,
   input  logic [1:0]           s,
   output logic [4*WIDTH-1:0]   Y
);

   // Stage 1 branch outputs
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;

   // Stage 2 leaf outputs (one per lane)
   logic [WIDTH-1:0] lane0;
   logic [WIDTH-1:0] lane1;
   logic [WIDTH-1:0] lane2;
   logic [WIDTH-1:0] lane3;

   logic [4*WIDTH-1:0] y_d;
   logic [4*WIDTH-1:0] y_q;

   // Stage 1 1x2 cell: split D on the upper select bit
   always_comb begin
      lo = '0;
      hi = '0;
      if (s[1]) begin
         hi = D;
      end else begin
         lo = D;
      end
   end

   // Stage 2 1x2 cells: split each branch on the lower select bit
   always_comb begin
      lane0 = '0;
      lane1 = '0;
      lane2 = '0;
      lane3 = '0;
      if (s[0]) begin
         lane1 = lo;
         lane3 = hi;
      end else begin
         lane0 = lo;
         lane2 = hi;
      end
   end

   // Pack the lanes into the output word, lane 0 in the least significant slice
   always_comb begin
      y_d = {lane3, lane2, lane1, lane0};
   end

   // Output register: synchronous reset wins over enable; en=0 holds the last result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q <= '0;
      end else if (en) begin
         y_q <= y_d;
      end
   end

   assign Y = y_q;

endmodule

// File: tb/tb_demux_1x4.sv
// Self-checking bench for demux_1x4: a WIDTH=1 and a WIDTH=8 instance share clock, reset
// and enable. Expected outputs come from a shift-based model of "lane s carries D".
module tb_demux_1x4;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        d1;
   logic [1:0]  s1;
   logic [3:0]  y1;
   logic [7:0]  d8;
   logic [1:0]  s8;
   logic [31:0] y8;

   // Model state: expected registered outputs
   logic [3:0]  exp1;
   logic [31:0] exp8;

   int passed;
   int total;

   demux_1x4 #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .D     (d1),
      .s     (s1),
      .Y     (y1)
   );

   demux_1x4 #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .D     (d8),
      .s     (s8),
      .Y     (y8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, update the model from the sampled inputs, settle 1 time unit.
   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         exp1 = '0;
         exp8 = '0;
      end else if (en) begin
         exp1 = 4'({3'b000, d1} << s1);
         exp8 = 32'({24'h0, d8} << (8 * int'(s8)));
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; d1 = 1'b1; s1 = 2'b10; d8 = 8'hFF; s8 = 2'b01;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (y1 !== 4'b0000) $display("FAIL reset1 edge%0d: got %b want 0000", i, y1);
         else passed++;
         total++;
         if (y8 !== 32'h0) $display("FAIL reset8 edge%0d: got %h want 0", i, y8);
         else passed++;
      end
      rst_n = 1'b1;
      step();
      total++;
      if (y1 !== 4'b0100) $display("FAIL reset_release: got %b want 0100", y1);
      else passed++;
      // rst_n pulsed low between edges must not disturb Y
      rst_n = 1'b0;
      #3;
      total++;
      if (y1 !== 4'b0100) $display("FAIL reset_between_edges: got %b want 0100", y1);
      else passed++;
      rst_n = 1'b1;
      step();
      total++;
      if (y1 !== 4'b0100) $display("FAIL reset_glitch_after: got %b want 0100", y1);
      else passed++;
   endtask

   task automatic test_select_sweep();
      logic [3:0] want [4];
      want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000;
      en = 1'b1; d1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s1 = 2'(i);
         step();
         total++;
         if (y1 !== want[i]) $display("FAIL sweep s=%0d: got %b want %b", i, y1, want[i]);
         else passed++;
      end
   endtask

   task automatic test_zero_data();
      en = 1'b1; d1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s1 = 2'(i);
         step();
         total++;
         if (y1 !== 4'b0000) $display("FAIL zero_data s=%0d: got %b want 0000", i, y1);
         else passed++;
      end
   endtask

   task automatic test_enable_hold();
      en = 1'b1; d1 = 1'b1; s1 = 2'b01;
      step();
      total++;
      if (y1 !== 4'b0010) $display("FAIL hold_load: got %b want 0010", y1);
      else passed++;
      en = 1'b0; s1 = 2'b11;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (y1 !== 4'b0010) $display("FAIL hold edge%0d: got %b want 0010", i, y1);
         else passed++;
      end
      en = 1'b1;
      step();
      total++;
      if (y1 !== 4'b1000) $display("FAIL hold_release: got %b want 1000", y1);
      else passed++;
   endtask

   task automatic test_mid_reset();
      en = 1'b1; d1 = 1'b1;
      s1 = 2'b00;
      step();
      total++;
      if (y1 !== 4'b0001) $display("FAIL midrst s=0: got %b want 0001", y1);
      else passed++;
      s1 = 2'b01;
      step();
      total++;
      if (y1 !== 4'b0010) $display("FAIL midrst s=1: got %b want 0010", y1);
      else passed++;
      s1 = 2'b10; rst_n = 1'b0;
      step();
      total++;
      if (y1 !== 4'b0000) $display("FAIL midrst asserted: got %b want 0000", y1);
      else passed++;
      s1 = 2'b11; rst_n = 1'b1;
      step();
      total++;
      if (y1 !== 4'b1000) $display("FAIL midrst resume: got %b want 1000", y1);
      else passed++;
   endtask

   task automatic test_wide_data();
      en = 1'b1;
      d8 = 8'hA5; s8 = 2'b10;
      step();
      total++;
      if (y8 !== 32'h00A5_0000) $display("FAIL wide_a5: got %h want 00a50000", y8);
      else passed++;
      d8 = 8'h3C; s8 = 2'b00;
      step();
      total++;
      if (y8 !== 32'h0000_003C) $display("FAIL wide_3c: got %h want 0000003c", y8);
      else passed++;
      d8 = 8'h81; s8 = 2'b11;
      step();
      total++;
      if (y8 !== 32'h8100_0000) $display("FAIL wide_81: got %h want 81000000", y8);
      else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         rst_n = ($urandom_range(0, 19) != 0);
         en    = ($urandom_range(0, 3) != 0);
         d1    = 1'($urandom);
         s1    = 2'($urandom);
         d8    = 8'($urandom);
         s8    = 2'($urandom);
         step();
         total++;
         if (y1 !== exp1) $display("FAIL random1 #%0d: got %b want %b", i, y1, exp1);
         else passed++;
         total++;
         if (y8 !== exp8) $display("FAIL random8 #%0d: got %h want %h", i, y8, exp8);
         else passed++;
      end
   endtask

   initial begin
      passed = 0;
      total  = 0;
      exp1   = '0;
      exp8   = '0;
      rst_n  = 1'b0;
      en     = 1'b0;
      d1     = 1'b0;
      s1     = 2'b00;
      d8     = 8'h00;
      s8     = 2'b00;
      #2;
      test_reset();
      test_select_sweep();
      test_zero_data();
      test_enable_hold();
      test_mid_reset();
      test_wide_data();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
